// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry, flush and stall counter.
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 4,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);
   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;
   localparam int W = CTRL_W + DATA_W;
   state_t         state_q;
   logic [W-1:0]   main_q, skid_q;
   logic [CNT_W-1:0] cnt_q;
   logic           accept, rel;
   assign out_valid = state_q != ST_EMPTY;
   // With the skid entry, in_ready comes straight from state so out_ready never reaches it
   assign in_ready  = (SKID != 0) ? (state_q != ST_SKID) : (~out_valid | out_ready);
   assign accept    = in_valid & in_ready;
   assign rel       = out_valid & out_ready;
   assign {out_ctrl, out_data} = main_q;
   assign stall_cnt = cnt_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         if (out_valid && !out_ready && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
         if (flush) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
         end else begin
            case (state_q)
               ST_EMPTY: if (accept) begin
                  state_q <= ST_FULL;
                  main_q  <= {in_ctrl, in_data};
               end
               ST_FULL: if (accept && rel) begin
                  main_q <= {in_ctrl, in_data};
               end else if (accept && SKID != 0) begin
                  state_q <= ST_SKID;
                  skid_q  <= {in_ctrl, in_data};
               end else if (rel) begin
                  state_q <= ST_EMPTY;
                  main_q  <= '0;
               end
               ST_SKID: if (rel) begin
                  state_q <= ST_FULL;
                  main_q  <= skid_q;
                  skid_q  <= '0;
               end
               default: begin
                  state_q <= ST_EMPTY;
                  main_q  <= '0;
                  skid_q  <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench driving a SKID=1 (CNT_W=4) and a SKID=0 instance in parallel.
module tb_pipe_stage_reg;
   logic clk = 1'b0;
   logic rst, flush, in_valid, out_ready;
   logic [3:0]  in_ctrl;
   logic [15:0] in_data;
   logic        rdy [2];
   logic        ov  [2];
   logic [3:0]  oc  [2];
   logic [15:0] od  [2];
   logic [3:0]  sc0;
   logic [15:0] sc1;
   logic [19:0] sb [2][$];
   int n [2];
   int cnt [2];
   int cmax [2] = '{15, 65535};
   int checks = 0, errors = 0;
   bit started = 0;
   bit m_rdy, m_acc, m_rel;
   logic [19:0] mon_w;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .SKID(1), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
      .out_ctrl(oc[0]), .out_data(od[0]), .stall_cnt(sc0));
   pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .SKID(0), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
      .out_ctrl(oc[1]), .out_data(od[1]), .stall_cnt(sc1));

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (plain); words are pushed on accept
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            sb[k].delete();
            n[k]   = 0;
            cnt[k] = 0;
            started = 1;
         end else begin
            m_rdy = (k == 0) ? (n[k] < 2) : (n[k] == 0 || out_ready);
            m_acc = in_valid && m_rdy;
            m_rel = n[k] > 0 && out_ready;
            if (n[k] > 0 && !out_ready && cnt[k] < cmax[k]) cnt[k]++;
            if (flush) begin
               sb[k].delete();
               n[k] = 0;
            end else begin
               n[k] = n[k] + int'(m_acc) - int'(m_rel);
               if (m_acc) sb[k].push_back({in_ctrl, in_data});
            end
         end
      end
   end

   // Monitor: compares presented words and flags; pops the scoreboard on each release
   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, 32'(ov[k]), 32'(n[k] > 0));
            chk("in_ready", k, 32'(rdy[k]), 32'((k == 0) ? (n[k] < 2) : (n[k] == 0 || out_ready)));
            chk("stall_cnt", k, (k == 0) ? 32'(sc0) : 32'(sc1), 32'(cnt[k]));
            if (!ov[k]) chk("bubble", k, {12'd0, oc[k], od[k]}, 32'd0);
            else if (out_ready) begin
               if (sb[k].size() == 0) chk("sb_underflow", k, {12'd0, oc[k], od[k]}, 32'hFFFFFFFF);
               else begin
                  mon_w = sb[k].pop_front();
                  chk("release_word", k, {12'd0, oc[k], od[k]}, {12'd0, mon_w});
               end
            end
         end
      end
   end

   task automatic step(input logic v, input logic [19:0] w, input logic r, input logic f);
      in_valid  = v;
      {in_ctrl, in_data} = w;
      out_ready = r;
      flush     = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_ctrl = 0; in_data = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;
      for (int i = 1; i <= 8; i++) step(1, 20'(i), 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(1, 20'hA, 1, 0);
      step(1, 20'hB, 0, 0);
      step(1, 20'hB, 0, 0);
      step(1, 20'hB, 0, 0);
      step(1, 20'hB, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("bp_stall", 0, 32'(sc0), 32'd3);
      chk("bp_stall", 1, 32'(sc1), 32'd3);
      step(1, 20'hA, 0, 0);
      step(1, 20'hB, 0, 0);
      step(1, 20'hC, 0, 1);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      for (int i = 0; i < 400; i++)
         step(1'($urandom % 2), 20'($urandom), ($urandom % 4) != 0, ($urandom % 16) == 0);
      for (int i = 0; i < 20; i++) step(1, 20'h77, 0, 0);
      chk("sat", 0, 32'(sc0), 32'd15);
      step(1, {4'b1010, 16'h5}, 0, 0);
      rst = 1;
      step(1, {4'b1010, 16'h5}, 0, 0);
      rst = 0;
      chk("rst_valid", 0, 32'(ov[0]), 32'd0);
      chk("rst_word", 0, {12'd0, oc[0], od[0]}, 32'd0);
      chk("rst_ready", 0, 32'(rdy[0]), 32'd1);
      chk("rst_cnt", 0, 32'(sc0), 32'd0);
      step(0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
